// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - pipeline freeze/flush controller for load-use stalls, memory waits and redirects
//
// Purpose: turns the load-use stall request, the data-memory wait handshake and
// branch/exception redirects into per-stage write enables and bubble flushes.
// Owns the memory-wait FSM, the deferred-flush flags and the wait timeout.
//
// Optional feature macro: PIPE_HOLD_STALL_CNT_EN (stall-cycle counters).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   _stall_en                     load-use request, 0 = stall
//   mem_req, mem_ready            data-memory access / completion
//   br_flush, exc_flush           branch redirect (EXE), exception redirect (MEM)
//   pc_we, *_we                   PC and pipeline register write enables
//   *_flush                       load a bubble into the pipeline register
//   mem_timeout                   registered; current wait reached WAIT_MAX cycles
//   lu_cnt, mw_cnt                load-use / memory-wait stall-cycle counters

module pipe_hold_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        _stall_en,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        br_flush,
  input  logic        exc_flush,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_exe_we,
  output logic        exe_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_exe_flush,
  output logic        exe_mem_flush,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
  output logic [31:0] lu_cnt,
  output logic [31:0] mw_cnt
);

  localparam logic [7:0] WAIT_MAX_8 = WAIT_MAX[7:0];

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wcnt;
  logic [7:0] wcnt_nxt;
  logic       pend_br;
  logic       pend_exc;

  logic wait_now;
  logic exc_eff;
  logic br_eff;

  assign wait_now = mem_req & ~mem_ready;
  // Redirects seen during a wait are replayed from the pending flags.
  assign exc_eff  = exc_flush | pend_exc;
  assign br_eff   = br_flush | pend_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wcnt        <= 8'd0;
      pend_br     <= 1'b0;
      pend_exc    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      // Compares the current count, so the flag trails wcnt by one cycle.
      mem_timeout <= (wcnt >= WAIT_MAX_8);
      if (wait_now) begin
        pend_br  <= pend_br | br_flush;
        pend_exc <= pend_exc | exc_flush;
      end else begin
        // First non-waiting cycle applies the deferred flush, so drop both.
        pend_br  <= 1'b0;
        pend_exc <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (wait_now) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!wait_now) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt != 8'hff) begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_exe_we     = 1'b1;
    exe_mem_we    = 1'b1;
    mem_wb_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_exe_we     = 1'b0;
      exe_mem_we    = 1'b0;
      mem_wb_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (wait_now) begin
      // Freeze everything up to MEM; let a bubble drain into WB.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_exe_we    = 1'b0;
      exe_mem_we   = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (exc_eff) begin
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (br_eff) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (!_stall_en) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

`ifdef PIPE_HOLD_STALL_CNT_EN
  logic [31:0] lu_q;
  logic [31:0] mw_q;
  logic        lu_apply;

  assign lu_apply = ~wait_now & ~exc_eff & ~br_eff & ~_stall_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q <= 32'd0;
      mw_q <= 32'd0;
    end else begin
      if (lu_apply) lu_q <= lu_q + 32'd1;
      if (wait_now) mw_q <= mw_q + 32'd1;
    end
  end

  assign lu_cnt = lu_q;
  assign mw_cnt = mw_q;
`else
  assign lu_cnt = 32'd0;
  assign mw_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb/tb_pipe_hold_ctrl.sv - self-checking bench for pipe_hold_ctrl (WAIT_MAX 255 and 4)

module tb_pipe_hold_ctrl;

  // Control vector layout: {pc, if_id, id_exe, exe_mem, mem_wb write enables,
  //                         if_id, id_exe, exe_mem, mem_wb flushes}
  localparam logic [8:0] P_RST  = 9'b00000_1111;
  localparam logic [8:0] P_WAIT = 9'b00001_0001;
  localparam logic [8:0] P_EXC  = 9'b11111_1110;
  localparam logic [8:0] P_BR   = 9'b11111_1100;
  localparam logic [8:0] P_LU   = 9'b00111_0100;
  localparam logic [8:0] P_NRM  = 9'b11111_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic stall_n = 1'b1;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;
  logic br = 1'b0;
  logic exc = 1'b0;

  logic [8:0]  a_vec, b_vec;
  logic        a_to, b_to;
  logic [31:0] a_lu, a_mw, b_lu, b_mw;

  pipe_hold_ctrl dut_a (
    .clk(clk), .rst(rst), ._stall_en(stall_n), .mem_req(mem_req), .mem_ready(mem_ready),
    .br_flush(br), .exc_flush(exc),
    .pc_we(a_vec[8]), .if_id_we(a_vec[7]), .id_exe_we(a_vec[6]), .exe_mem_we(a_vec[5]),
    .mem_wb_we(a_vec[4]), .if_id_flush(a_vec[3]), .id_exe_flush(a_vec[2]),
    .exe_mem_flush(a_vec[1]), .mem_wb_flush(a_vec[0]),
    .mem_timeout(a_to), .lu_cnt(a_lu), .mw_cnt(a_mw)
  );

  pipe_hold_ctrl #(.WAIT_MAX(4)) dut_b (
    .clk(clk), .rst(rst), ._stall_en(stall_n), .mem_req(mem_req), .mem_ready(mem_ready),
    .br_flush(br), .exc_flush(exc),
    .pc_we(b_vec[8]), .if_id_we(b_vec[7]), .id_exe_we(b_vec[6]), .exe_mem_we(b_vec[5]),
    .mem_wb_we(b_vec[4]), .if_id_flush(b_vec[3]), .id_exe_flush(b_vec[2]),
    .exe_mem_flush(b_vec[1]), .mem_wb_flush(b_vec[0]),
    .mem_timeout(b_to), .lu_cnt(b_lu), .mw_cnt(b_mw)
  );

  // Behavioural model: a wait streak length, two "deferred redirect" booleans,
  // and a priority lookup from situation to control pattern.
  int          m_streak = 0;
  logic        m_to_a = 1'b0;
  logic        m_to_b = 1'b0;
  logic        m_pbr = 1'b0;
  logic        m_pexc = 1'b0;
  logic [31:0] m_lu = 32'd0;
  logic [31:0] m_mw = 32'd0;

  function automatic logic [8:0] exp_ctl(input logic r, input logic w, input logic e,
                                         input logic b, input logic sn);
    if (r)   return P_RST;
    if (w)   return P_WAIT;
    if (e)   return P_EXC;
    if (b)   return P_BR;
    if (!sn) return P_LU;
    return P_NRM;
  endfunction

  logic       m_w;
  logic [8:0] m_ctl;
  int         m_cap;
  assign m_w   = mem_req & ~mem_ready;
  assign m_ctl = exp_ctl(rst, m_w, exc | m_pexc, br | m_pbr, stall_n);
  assign m_cap = (m_streak > 255) ? 255 : m_streak;

  always @(posedge clk) begin
    if (rst) begin
      m_streak <= 0;
      m_to_a   <= 1'b0;
      m_to_b   <= 1'b0;
      m_pbr    <= 1'b0;
      m_pexc   <= 1'b0;
      m_lu     <= 32'd0;
      m_mw     <= 32'd0;
    end else begin
      m_streak <= m_w ? m_streak + 1 : 0;
      m_to_a   <= (m_cap >= 255);
      m_to_b   <= (m_cap >= 4);
      m_pbr    <= m_w & (m_pbr | br);
      m_pexc   <= m_w & (m_pexc | exc);
      m_lu     <= m_lu + ((m_ctl == P_LU) ? 32'd1 : 32'd0);
      m_mw     <= m_mw + (m_w ? 32'd1 : 32'd0);
    end
  end

  logic [31:0] e_lu, e_mw;
`ifdef PIPE_HOLD_STALL_CNT_EN
  assign e_lu = m_lu;
  assign e_mw = m_mw;
`else
  assign e_lu = 32'd0;
  assign e_mw = 32'd0;
`endif

  // Literal expectations set by the directed sequence (-1 = not checked).
  logic       chk_en = 1'b0;
  logic       lit_v = 1'b0;
  logic [8:0] lit_ctl = 9'd0;
  int         lit_to = -1;
  int         lit_lu = -1;
  int         lit_mw = -1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec = n_vec + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl_a", 32'(a_vec), 32'(m_ctl));
      chk("ctl_b", 32'(b_vec), 32'(m_ctl));
      chk("timeout_a", 32'(a_to), 32'(m_to_a));
      chk("timeout_b", 32'(b_to), 32'(m_to_b));
      chk("lu_cnt_a", a_lu, e_lu);
      chk("mw_cnt_a", a_mw, e_mw);
      chk("lu_cnt_b", b_lu, e_lu);
      chk("mw_cnt_b", b_mw, e_mw);
      if (lit_v) begin
        chk("lit_ctl_model", 32'(m_ctl), 32'(lit_ctl));
        chk("lit_ctl_dut", 32'(a_vec), 32'(lit_ctl));
      end
      if (lit_to >= 0) begin
        chk("lit_to_model", 32'(m_to_b), 32'(lit_to));
        chk("lit_to_dut", 32'(b_to), 32'(lit_to));
        chk("lit_to255_dut", 32'(a_to), 32'd0);
      end
`ifdef PIPE_HOLD_STALL_CNT_EN
      if (lit_lu >= 0) chk("lit_lu", a_lu, 32'(lit_lu));
      if (lit_mw >= 0) chk("lit_mw", a_mw, 32'(lit_mw));
`else
      if (lit_lu >= 0) chk("lit_lu", a_lu, 32'd0);
      if (lit_mw >= 0) chk("lit_mw", a_mw, 32'd0);
`endif
    end
  end

  task automatic drive(input logic r, input logic sn, input logic mq, input logic mr,
                       input logic b, input logic e, input logic lv, input logic [8:0] lc,
                       input int tl, input int ll, input int ml);
    @(posedge clk);
    #1;
    rst = r; stall_n = sn; mem_req = mq; mem_ready = mr; br = b; exc = e;
    lit_v = lv; lit_ctl = lc; lit_to = tl; lit_lu = ll; lit_mw = ml;
    chk_en = 1'b1;
  endtask

  initial begin
    // Reset
    drive(1, 1, 0, 0, 0, 0, 1, P_RST, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1, P_RST, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, 0, 0, 0);
    // Load-use, one cycle
    drive(0, 0, 0, 0, 0, 0, 1, P_LU, -1, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, -1, 1, 0);
    // Memory wait of 3 cycles then ready
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 1, P_WAIT, 0, -1, -1);
    drive(0, 1, 1, 1, 0, 0, 1, P_NRM, 0, 1, 3);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, 0, 1, 3);
    // Branch in wait cycle 2 of 4, replayed when ready rises
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, (i == 1), 0, 1, P_WAIT, -1, -1, -1);
    drive(0, 1, 1, 1, 0, 0, 1, P_BR, -1, -1, 7);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, -1, 1, 7);
    // Priority: exception beats branch and load-use
    drive(0, 0, 0, 0, 1, 1, 1, P_EXC, -1, -1, -1);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, -1, 1, 7);
    // Timeout with WAIT_MAX=4: ten wait cycles, then exit
    for (int c = 1; c <= 10; c++) drive(0, 1, 1, 0, 0, 0, 1, P_WAIT, (c >= 6) ? 1 : 0, -1, -1);
    drive(0, 1, 1, 1, 0, 0, 1, P_NRM, 1, -1, 17);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, 1, -1, 17);
    drive(0, 1, 0, 0, 0, 0, 1, P_NRM, 0, -1, 17);
    // Reset mid-wait with a deferred exception
    drive(0, 1, 1, 0, 0, 0, 1, P_WAIT, -1, -1, -1);
    drive(0, 1, 1, 0, 0, 1, 1, P_WAIT, -1, -1, -1);
    drive(1, 1, 1, 0, 0, 0, 1, P_RST, -1, -1, -1);
    drive(1, 1, 1, 0, 0, 0, 1, P_RST, -1, -1, -1);
    drive(0, 1, 1, 1, 0, 0, 1, P_NRM, 0, 0, 0);
    // Randomized traffic; every 40 cycles pick a fast or slow memory regime
    for (int blk = 0; blk < 25; blk++) begin
      int slow;
      slow = ($urandom_range(0, 2) == 0) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
        drive(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 1) == 0) || (slow != 0),
              slow ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 9) < 5),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0),
              0, 9'd0, -1, -1, -1);
      end
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Consumer of the load-use stall request (`_stall_en`, active-low) and the data-memory wait handshake. It turns those requests, plus branch and exception redirects, into per-stage write-enables and flushes for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It sits beside the hazard unit in the core top level. It holds the only sequential pipeline-freeze state: the memory-wait FSM, deferred flushes and a wait timeout.

## Interface
Parameters:
- `WAIT_MAX`, default 255: memory-wait cycles before `mem_timeout` asserts. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `_stall_en`  in  1  load-use request from the hazard unit; 0 = stall, 1 = no stall.
- `mem_req`  in  1  instruction in MEM is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `br_flush`  in  1  taken branch/jump resolved in EXE.
- `exc_flush`  in  1  exception/eret redirect raised in MEM.
- `pc_we`  out  1  PC register write enable.
- `if_id_we`, `id_exe_we`, `exe_mem_we`, `mem_wb_we`  out  1 each  pipeline register write enables.
- `if_id_flush`, `id_exe_flush`, `exe_mem_flush`, `mem_wb_flush`  out  1 each  load a bubble (all-zero control) into the register.
- `mem_timeout`  out  1  registered; high while the current wait has lasted at least `WAIT_MAX` cycles.
- `lu_cnt`, `mw_cnt`  out  32 each  stall-cycle counters (see Configuration).

## Operation
- States: `RUN`, `MEM_WAIT`. The 8-bit wait counter `wcnt` and the flags `pend_br` and `pend_exc` are registered.
- Outputs are combinational from the state, the registered flags and the inputs.
- **Waiting condition:** `wait_now = mem_req & ~mem_ready`. It is evaluated in both states.
- **Memory stall:** while `wait_now` is high:
  - `pc_we`, `if_id_we`, `id_exe_we` and `exe_mem_we` are 0.
  - `mem_wb_we` is 1 and `mem_wb_flush` is 1, so the bubble drains into WB.
  - All other flushes are 0 and `_stall_en` is ignored.
- **Flushes during a memory stall:** a `br_flush` or `exc_flush` seen while `wait_now` is high sets `pend_br` or `pend_exc`.
- **Exception flush** (`exc_flush | pend_exc`, not waiting):
  - `pc_we` is 1.
  - `if_id_flush`, `id_exe_flush` and `exe_mem_flush` are 1.
  - All write enables are 1.
- **Branch flush** (`br_flush | pend_br`, no exception, not waiting):
  - `pc_we` is 1.
  - `if_id_flush` and `id_exe_flush` are 1.
- **Load-use stall** (`_stall_en == 0`, no flush, not waiting):
  - `pc_we` and `if_id_we` are 0.
  - `id_exe_flush` is 1.
  - `id_exe_we`, `exe_mem_we` and `mem_wb_we` are 1.
- **Normal flow:** all write enables are 1 and all flushes are 0.
- **Priority:** memory wait > exception > branch > load-use > normal.
- **Pending flags** clear on the first cycle with `wait_now` low, the cycle in which they take effect. An exception also clears `pend_br`.
- **Transitions:**
  - `RUN` → `MEM_WAIT` when `wait_now` is high; `wcnt` loads 1.
  - `MEM_WAIT` → `RUN` when `mem_ready` is high or `mem_req` drops; `wcnt` clears.
  - While in `MEM_WAIT`, `wcnt` increments and saturates at 255.
- **Timeout:** `mem_timeout` is high while `wcnt >= WAIT_MAX`. It clears on the cycle after leaving `MEM_WAIT`. The freeze continues regardless of timeout.

## Timing
- **Reset:** with `rst` high at an edge:
  - The state goes to `RUN`, and `wcnt`, `pend_br`, `pend_exc`, `mem_timeout` and both counters go to 0.
  - While `rst` is high, all `*_we` outputs are 0 and all `*_flush` outputs are 1.
- **Reset mid-wait:** discards pending flushes. The first cycle after reset is `RUN`.
- **Latency:** enables and flushes respond in the same cycle as their inputs (zero latency). `mem_timeout` lags `wcnt` by one cycle because it is registered.
- **Load-use:** produces exactly one frozen cycle per cycle `_stall_en` is low. No state is kept.
- **Wait completion:** a 1-cycle access (`mem_ready` high with `mem_req`) never freezes. An N-cycle access freezes for N−1 cycles.
- **Deferred flushes:** a flush deferred by a wait is applied in the cycle `mem_ready` rises.

## Configuration
- `PIPE_HOLD_STALL_CNT_EN` defined:
  - `lu_cnt` increments on every cycle in which the load-use stall is applied (not overridden).
  - `mw_cnt` increments on every `wait_now` cycle.
  - Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Not defined: no counter registers exist, and `lu_cnt` and `mw_cnt` are tied to 0.

## Test plan
- **Load-use:** `_stall_en=0` for 1 cycle, no other input → `pc_we=0`, `if_id_we=0`, `id_exe_flush=1` that cycle. The next cycle has all enables 1. `lu_cnt` becomes 1 (macro on).
- **Memory wait:** `mem_req=1`, `mem_ready` low for 3 cycles then high → 3 frozen cycles with `mem_wb_flush=1`, then normal flow. `mw_cnt=3`. `mem_timeout` stays 0 with `WAIT_MAX=255`.
- **Branch during wait:** `br_flush` pulsed in wait cycle 2 of 4 → no flush during the wait. `if_id_flush=1`, `id_exe_flush=1` and `pc_we=1` in the cycle `mem_ready` rises.
- **Priority:** `exc_flush=1`, `br_flush=1`, `_stall_en=0` together, no wait → `exe_mem_flush=1`, `pc_we=1`, `if_id_we=1`, all three lower flushes 1.
- **Timeout:** `WAIT_MAX=4`, `mem_ready` held low for 10 cycles → `mem_timeout` rises one cycle after `wcnt` reaches 4, holds, and clears one cycle after the exit.
- **Reset mid-wait:** `rst` pulsed during a wait with `pend_exc` set → all `*_we` outputs 0 and all flushes 1 during reset. After reset, no deferred flush is applied.
